// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order fetch requests, buffers the
// returned words with their PCs, and presents them to decode. A redirect
// flushes the buffer and remembers how many responses are still owed so they
// can be thrown away when they arrive.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
    parameter int              BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            ValidD,
    input  logic            ReadyD,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(BUF_DEPTH);

    logic [XLEN-1:0]      r_pcf;
    logic [XLEN-1:0]      r_pc_q    [BUF_DEPTH];
    logic [31:0]          r_instr_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_filled;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [PW-1:0]        r_fill;
    logic [CW-1:0]        r_alloc_cnt;
    logic [CW-1:0]        r_pend_cnt;
    logic [CW-1:0]        r_drop_cnt;

    logic                 w_req_valid;
    logic                 w_hs;
    logic                 w_valid_d;
    logic                 w_pop;
    logic                 w_rsp;
    logic                 w_rsp_drop;
    logic                 w_rsp_fill;
    logic [CW-1:0]        w_inflight;
    logic [CW-1:0]        w_flush_drop;
    logic [BUF_DEPTH-1:0] w_filled_nxt;

    // Occupancy counts both live entries and responses still owed from before a redirect.
    assign w_req_valid = rst && !PCSrcE &&
                         (({1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt}) < L_DEPTH);
    assign w_hs        = w_req_valid && imem_req_ready;
    assign w_valid_d   = rst && r_filled[r_head] && !PCSrcE;
    assign w_pop       = w_valid_d && ReadyD;
    assign w_rsp       = rst && imem_rsp_valid;
    assign w_rsp_drop  = w_rsp && (r_drop_cnt != '0);
    assign w_rsp_fill  = w_rsp && (r_drop_cnt == '0) && (r_pend_cnt != '0) && !PCSrcE;

    // On a redirect every request still in flight becomes a drop, less any response landing now.
    assign w_inflight   = r_drop_cnt + r_pend_cnt;
    assign w_flush_drop = (w_rsp && (w_inflight != '0)) ? (w_inflight - CW'(1)) : w_inflight;

    // Next filled flags: pop clears head, response sets oldest unfilled, allocate clears tail.
    always_comb begin
        w_filled_nxt = r_filled;
        if (w_pop)      w_filled_nxt[r_head] = 1'b0;
        if (w_rsp_fill) w_filled_nxt[r_fill] = 1'b1;
        if (w_hs)       w_filled_nxt[r_tail] = 1'b0;
    end

    // Fetch PC, buffer pointers and occupancy counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcf       <= RESET_PC;
            r_head      <= '0;
            r_tail      <= '0;
            r_fill      <= '0;
            r_filled    <= '0;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else if (PCSrcE) begin
            r_pcf       <= PCTargetE;
            r_head      <= '0;
            r_tail      <= '0;
            r_fill      <= '0;
            r_filled    <= '0;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_drop_cnt  <= w_flush_drop;
        end else begin
            if (w_hs) begin
                r_pcf  <= r_pcf + XLEN'(4);
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop)      r_head     <= r_head + PW'(1);
            if (w_rsp_fill) r_fill     <= r_fill + PW'(1);
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
            r_filled    <= w_filled_nxt;
            r_alloc_cnt <= r_alloc_cnt + CW'(w_hs) - CW'(w_pop);
            r_pend_cnt  <= r_pend_cnt + CW'(w_hs) - CW'(w_rsp_fill);
        end
    end

    // Buffer payload; validity lives in r_filled so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_hs)       r_pc_q[r_tail]    <= r_pcf;
        if (w_rsp_fill) r_instr_q[r_fill] <= imem_rsp_data;
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pcf;
    assign ValidD         = w_valid_d;
    assign InstrD         = w_valid_d ? r_instr_q[r_head] : 32'h0;
    assign PCD            = w_valid_d ? r_pc_q[r_head] : '0;
    assign PCPlus4D       = w_valid_d ? (r_pc_q[r_head] + XLEN'(4)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCSrcE, imem_req_ready, imem_rsp_valid, ReadyD;
    logic [31:0] PCTargetE, imem_rsp_data;
    logic        imem_req_valid, ValidD;
    logic [31:0] imem_req_addr, InstrD, PCD, PCPlus4D;

    logic        b_rst, b_PCSrcE, b_req_ready, b_rsp_valid, b_ReadyD;
    logic [31:0] b_PCTargetE, b_rsp_data;
    logic        b_req_valid, b_ValidD;
    logic [31:0] b_req_addr, b_InstrD, b_PCD, b_PCPlus4D;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .ValidD(ValidD), .ReadyD(ReadyD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_w (
        .clk(clk), .rst(b_rst), .PCSrcE(b_PCSrcE), .PCTargetE(b_PCTargetE),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
        .imem_req_addr(b_req_addr), .imem_rsp_valid(b_rsp_valid),
        .imem_rsp_data(b_rsp_data), .ValidD(b_ValidD), .ReadyD(b_ReadyD),
        .InstrD(b_InstrD), .PCD(b_PCD), .PCPlus4D(b_PCPlus4D)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: ordered list of fetched entries and a count of owed responses.
    typedef struct { logic [31:0] pc; bit filled; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    ent_t        mq[$];
    mreq_t       memq[$];
    logic [31:0] m_pcf;
    int          m_drop;
    int          lat   = 1;
    int          cyc_n = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic model_reset();
        mq.delete();
        memq.delete();
        m_pcf  = 32'h0;
        m_drop = 0;
    endtask

    // One clock cycle: memory drives its response, outputs are checked, model advances.
    task automatic cyc();
        bit m_rv, m_vd, done;
        int unf;
        if (memq.size() > 0 && memq[0].due <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        m_rv = (mq.size() + m_drop < 4) && !PCSrcE;
        m_vd = (mq.size() > 0) && mq[0].filled && !PCSrcE;
        chk1("req_valid", imem_req_valid, m_rv);
        chk("req_addr", imem_req_addr, m_pcf);
        chk1("ValidD", ValidD, m_vd);
        chk("InstrD", InstrD, m_vd ? mq[0].data : 32'h0);
        chk("PCD", PCD, m_vd ? mq[0].pc : 32'h0);
        chk("PCPlus4D", PCPlus4D, m_vd ? mq[0].pc + 32'h4 : 32'h0);
        if (imem_req_valid && imem_req_ready)
            memq.push_back('{imem_req_addr, cyc_n + lat});
        if (PCSrcE) begin
            unf = m_drop;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            if (imem_rsp_valid && unf > 0) unf--;
            m_drop = unf;
            mq.delete();
            m_pcf = PCTargetE;
        end else begin
            if (m_vd && ReadyD) void'(mq.pop_front());
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    done = 1'b0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!done && !mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].data   = imem_rsp_data;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (m_rv && imem_req_ready) begin
                mq.push_back('{m_pcf, 1'b0, 32'h0});
                m_pcf = m_pcf + 32'h4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset(input bit check);
        #3;
        rst = 1'b0;
        #1;
        if (check) begin
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_ValidD", ValidD, 1'b0);
            chk("rst_InstrD", InstrD, 32'h0);
            chk("rst_PCD", PCD, 32'h0);
            chk("rst_PCPlus4D", PCPlus4D, 32'h0);
            chk("rst_addr", imem_req_addr, 32'h0);
        end
        model_reset();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs until the first valid decode word (bounded) and pins it to a literal.
    task automatic expect_first(input string name, input logic [31:0] pc);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (ValidD) begin
                seen = 1'b1;
                chk({name, "_PCD"}, PCD, pc);
                chk({name, "_PCPlus4D"}, PCPlus4D, pc + 32'h4);
                chk({name, "_InstrD"}, InstrD, pc ^ 32'hC0DE0000);
            end
            cyc();
        end
        chk1({name, "_seen"}, seen, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_req, first_v, nreq;
        logic [31:0] pcs[$];
        bit found;

        rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; ReadyD = 1'b1;
        b_rst = 1'b0; b_PCSrcE = 1'b0; b_PCTargetE = 32'h0; b_req_ready = 1'b0;
        b_rsp_valid = 1'b0; b_rsp_data = 32'h0; b_ReadyD = 1'b0;
        #1;
        chk1("init_req_valid", imem_req_valid, 1'b0);
        chk1("init_ValidD", ValidD, 1'b0);
        chk("init_PCD", PCD, 32'h0);
        chk1("init_w_ValidD", b_ValidD, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming: one word per cycle, first ValidD two cycles after first request.
        first_req = -1; first_v = -1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (imem_req_valid && first_req < 0) first_req = cyc_n;
            if (ValidD) begin
                if (first_v < 0) first_v = cyc_n;
                pcs.push_back(PCD);
            end
            cyc();
        end
        chk("first_valid_latency", first_v - first_req, 2);
        chk("stream_count", pcs.size(), 10);
        foreach (pcs[i]) chk("stream_pcd", pcs[i], 32'(i * 4));

        // Async reset mid-stream, then decode stalls: buffer fills with 4 requests.
        ReadyD = 1'b0;
        do_reset(1'b1);
        nreq = 0;
        #1;
        chk("post_reset_addr", imem_req_addr, 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imem_req_valid && imem_req_ready) nreq++;
            cyc();
        end
        #1;
        chk("stall_requests", nreq, 4);
        chk1("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_addr", imem_req_addr, 32'h10);
        chk1("stall_ValidD", ValidD, 1'b1);
        chk("stall_PCD", PCD, 32'h0);
        chk("stall_InstrD", InstrD, 32'hC0DE0000);
        ReadyD = 1'b1;
        repeat (8) cyc();

        // Redirect with two requests in flight; both stale responses are dropped.
        do_reset(1'b0);
        lat = 3;
        cyc();
        cyc();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        cyc();
        PCSrcE = 1'b0;
        #1;
        chk("redirect_addr", imem_req_addr, 32'h100);
        chk1("redirect_req_valid", imem_req_valid, 1'b1);
        expect_first("redir", 32'h100);

        // Redirect in the same cycle as a response with decode ready.
        lat = 1;
        repeat (6) cyc();
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            if (memq.size() > 0 && memq[0].due <= cyc_n) found = 1'b1;
            else cyc();
        end
        chk1("rsp_pending_for_redirect", found, 1'b1);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        #1;
        chk1("redirect_blocks_ValidD", ValidD, 1'b0);
        chk1("redirect_blocks_req", imem_req_valid, 1'b0);
        cyc();
        PCSrcE = 1'b0;
        expect_first("redir_rsp", 32'h200);

        // Back-to-back redirects: the last target wins.
        lat = 2;
        repeat (3) cyc();
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        cyc();
        PCTargetE = 32'h400;
        cyc();
        PCSrcE = 1'b0;
        #1;
        chk("b2b_addr", imem_req_addr, 32'h400);
        expect_first("b2b", 32'h400);

        // Mixed backpressure on both sides with a double redirect in the middle.
        for (int k = 0; k < 40; k++) begin
            imem_req_ready = (k % 3) != 0;
            ReadyD         = (k % 5) != 2;
            lat            = 1 + (k % 3);
            PCSrcE         = (k == 20) || (k == 21);
            PCTargetE      = (k == 20) ? 32'h500 : 32'h600;
            cyc();
        end
        PCSrcE = 1'b0; imem_req_ready = 1'b1; ReadyD = 1'b1;
        repeat (10) cyc();

        // Wrap of the PC arithmetic from RESET_PC = 0xFFFFFFFC.
        b_rst = 1'b1; b_req_ready = 1'b1; b_ReadyD = 1'b0;
        #1;
        chk("wrap_first_addr", b_req_addr, 32'hFFFFFFFC);
        chk1("wrap_req_valid", b_req_valid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        b_req_ready = 1'b0;
        b_rsp_valid = 1'b1;
        b_rsp_data  = 32'h12345678;
        #1;
        chk("wrap_next_addr", b_req_addr, 32'h0);
        chk1("wrap_ValidD_latency", b_ValidD, 1'b0);
        @(posedge clk);
        @(negedge clk);
        b_rsp_valid = 1'b0;
        #1;
        chk1("wrap_ValidD", b_ValidD, 1'b1);
        chk("wrap_PCD", b_PCD, 32'hFFFFFFFC);
        chk("wrap_PCPlus4D", b_PCPlus4D, 32'h0);
        chk("wrap_InstrD", b_InstrD, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-003 SHALL provide parameter BUF_DEPTH, default 4, meaning instruction-buffer entries (power of 2, >=2).
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- PCSrcE  input  1  redirect request from execute.
- PCTargetE  input  XLEN  redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address.
- imem_rsp_valid  input  1  in-order response valid.
- imem_rsp_data  input  32  response instruction.
- ValidD  output  1  decode-side instruction valid.
- ReadyD  input  1  decode accepts instruction.
- InstrD  output  32  instruction to decode.
- PCD  output  XLEN  PC of InstrD.
- PCPlus4D  output  XLEN  PCD+4.

Function
REQ-005 SHALL hold fetch PC register pcf; imem_req_addr = pcf.
REQ-006 Request handshake = imem_req_valid && imem_req_ready; on handshake pcf <= pcf+4 modulo 2^XLEN and one buffer entry is allocated in order, tagged with pcf.
REQ-007 imem_req_valid SHALL = (alloc_cnt + drop_cnt < BUF_DEPTH) && !PCSrcE, using registered counts only (no same-cycle pop bypass).
REQ-008 Each live imem_rsp_valid SHALL fill the oldest unfilled allocated entry with imem_rsp_data; imem_rsp_valid while no request outstanding SHALL be ignored.
REQ-009 ValidD SHALL = (head entry filled) && !PCSrcE; data captured at edge N is visible at ValidD after edge N (1-cycle latency, registered).
REQ-010 InstrD/PCD/PCPlus4D SHALL show head entry when ValidD=1, else all zero; PCPlus4D = PCD+4 modulo 2^XLEN.
REQ-011 Pop on ValidD && ReadyD; outputs hold stable while ValidD=1 and ReadyD=0.
REQ-012 On PCSrcE=1 at an edge: pcf <= PCTargetE; all buffer entries invalidated; no pop, no request; drop_cnt <= number of requests still in flight after any response this cycle; a response in that cycle is discarded.
REQ-013 While drop_cnt>0, each imem_rsp_valid SHALL decrement drop_cnt and be discarded before any live entry is filled.
REQ-014 Simultaneous allocate and pop SHALL both take effect; head/tail pointers wrap modulo BUF_DEPTH.
REQ-015 Back-to-back redirects SHALL each reload pcf; last one wins; drop_cnt never exceeds BUF_DEPTH.

Reset
REQ-016 rst=0 SHALL asynchronously set pcf=RESET_PC, alloc_cnt=0, drop_cnt=0, pointers=0, all entries empty.
REQ-017 While rst=0: imem_req_valid=0, ValidD=0, InstrD/PCD/PCPlus4D=0; responses ignored.
REQ-018 After rst release, first request issues with imem_req_addr=RESET_PC; responses to pre-reset requests are not the design's concern.

Verification
REQ-019 Bench SHALL cover:
- Reset release, memory ready=1, response 1 cycle after request, ReadyD=1 -> PCD 0x0,0x4,0x8,... one per cycle; InstrD matches memory; first ValidD 2 cycles after first request.
- ReadyD=0 for 10 cycles -> exactly 4 requests (0x0..0xC), imem_req_valid=0, imem_req_addr=0x10; PCD held 0x0.
- 2 requests in flight, PCSrcE=1 with PCTargetE=0x100 -> both stale responses dropped, next request addr 0x100, first ValidD shows PCD=0x100, PCPlus4D=0x104.
- PCSrcE=1 same cycle as response and ReadyD=1 -> ValidD=0 that cycle, no pop, response discarded.
- rst driven low mid-stream -> all outputs 0 without clock edge; after release imem_req_addr=RESET_PC.
- RESET_PC=0xFFFFFFFC -> PCD=0xFFFFFFFC, PCPlus4D=0x0, next request addr 0x0.
